// File: rtl/prompt_uart_tx_pkg.sv
// Shared definitions for the prompt streamer: FSM encoding, the string
// terminator and the default bit period for a 27 MHz clock at 115200 baud.
package prompt_uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LATCH = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5,
    FIN   = 3'd6
  } state_t;

  localparam logic [7:0] TERMINATOR           = 8'h00;
  localparam int         DEFAULT_CLKS_PER_BIT = 234;

endpackage

// File: rtl/prompt_uart_tx_baud_tick.sv
// Bit-period timer: while enabled, emits a one-cycle tick on the last cycle
// of every CLKS_PER_BIT-cycle period; held at zero while disabled.
module uart_baud_tick
  import prompt_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic tick
);

  localparam int               CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  // NOTE: clocked state is always written with <= so every flop samples the
  // pre-edge value of its inputs, independent of process ordering.
  always_ff @(posedge clk) begin
    if (!reset_n || !en || cnt == LAST) cnt <= '0;
    else                                cnt <= cnt + 1'b1;
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/prompt_uart_tx.sv
// Prompt streamer: walks the prompt ROM from address 0 and sends each stored
// (bit-reversed) byte MSB-first as an 8N1 frame until a zero byte or the last address.
module prompt_uart_tx
  import prompt_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int ADDR_W       = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_ad,
  output logic              rom_ce,
  output logic              rom_oce,
  input  logic [7:0]        rom_dout,
  output logic              tx
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr, addr_nx;
  logic [7:0]        shreg, shreg_nx;
  logic [2:0]        bit_cnt, bit_cnt_nx;
  logic              tx_nx;
  logic              baud_en;
  logic              tick;

  // One timer serves the start, data and stop periods back to back.
  assign baud_en = (state == START) || (state == DATA) || (state == STOP);

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (baud_en),
    .tick   (tick)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      addr    <= '0;
      shreg   <= '0;
      bit_cnt <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_nx;
      addr    <= addr_nx;
      shreg   <= shreg_nx;
      bit_cnt <= bit_cnt_nx;
      tx      <= tx_nx;
    end
  end

  // NOTE: every signal assigned here gets a default first, so no path through
  // the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_nx   = state;
    addr_nx    = addr;
    shreg_nx   = shreg;
    bit_cnt_nx = bit_cnt;
    case (state)
      IDLE: begin
        if (start) begin
          addr_nx  = '0;
          state_nx = FETCH;
        end
      end
      FETCH: state_nx = LATCH;
      LATCH: begin
        shreg_nx = rom_dout;
        state_nx = (rom_dout == TERMINATOR) ? FIN : START;
      end
      START: begin
        if (tick) begin
          bit_cnt_nx = '0;
          state_nx   = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          shreg_nx   = {shreg[6:0], 1'b0};
          bit_cnt_nx = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nx = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          if (addr == LAST_ADDR) begin
            state_nx = FIN;
          end else begin
            addr_nx  = addr + 1'b1;
            state_nx = FETCH;
          end
        end
      end
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Line level is derived from the next state so tx itself is a plain flop.
  always_comb begin
    case (state_nx)
      START:   tx_nx = 1'b0;
      DATA:    tx_nx = shreg_nx[7];
      default: tx_nx = 1'b1;
    endcase
  end

  assign busy    = (state != IDLE) && (state != FIN);
  assign done    = (state == FIN);
  assign rom_ce  = (state == FETCH);
  assign rom_ad  = addr;
  assign rom_oce = 1'b1;

endmodule

// File: tb/tb_prompt_uart_tx.sv
// Directed bench for prompt_uart_tx at 4 clocks per bit with a 1-cycle ROM
// model; a line decoder and event counters feed immediate-assertion checks.
module tb_prompt_uart_tx;

  localparam int CPB    = 4;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] rom_ad;
  logic              rom_ce;
  logic              rom_oce;
  logic [7:0]        rom_dout = 8'h00;
  logic              tx;

  logic [7:0] rom [16];

  int n_checks = 0;
  int n_fail   = 0;

  int cyc        = 0;
  int busy_cnt   = 0;
  int done_cnt   = 0;
  int done_cyc   = 0;
  int rom_ce_cnt = 0;
  int tx_low_cnt = 0;
  int frame_err  = 0;
  int ad_q[$];
  logic [9:0] frame_q[$];
  int start_q[$];

  logic [9:0] dec_w;
  int         dec_t0;
  bit         dec_bad;

  prompt_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .ADDR_W      (ADDR_W)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .rom_ad  (rom_ad),
    .rom_ce  (rom_ce),
    .rom_oce (rom_oce),
    .rom_dout(rom_dout),
    .tx      (tx)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (rom_ce) rom_dout <= rom[rom_ad];

  always @(negedge clk) begin
    if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
    if (done === 1'b1) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (rom_ce === 1'b1) begin
      rom_ce_cnt <= rom_ce_cnt + 1;
      ad_q.push_back(int'(rom_ad));
    end
    if (tx === 1'b0) tx_low_cnt <= tx_low_cnt + 1;
  end

  // Line decoder: a low sample opens a 10-bit frame; each bit must hold steady.
  always begin
    @(negedge clk);
    if (tx === 1'b0) begin
      dec_t0  = cyc;
      dec_bad = 1'b0;
      dec_w   = '0;
      for (int b = 0; b < 10; b++) begin
        for (int k = 0; k < CPB; k++) begin
          if (b != 0 || k != 0) @(negedge clk);
          if (k == 0) dec_w[b] = tx;
          else if (tx !== dec_w[b]) dec_bad = 1'b1;
        end
      end
      frame_q.push_back(dec_w);
      start_q.push_back(dec_t0);
      if (dec_bad) frame_err++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(output int s);
    @(negedge clk);
    start = 1'b1;
    s     = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int base, input int limit, input string tag);
    int n;
    n = 0;
    while (done_cnt == base && n < limit) begin
      @(posedge clk);
      n++;
    end
    check(tag, 32'(done_cnt != base), 32'd1);
  endtask

  task automatic load_echo();
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    rom[0] = 8'hA6;
    rom[1] = 8'hC6;
    rom[2] = 8'h16;
    rom[3] = 8'hF6;
    rom[4] = 8'h7C;
  endtask

  task automatic load_fill(input logic [7:0] v);
    for (int i = 0; i < 16; i++) rom[i] = v;
  endtask

  initial begin
    int s;
    int b_frames, b_done, b_busy, b_ce, b_ad, b_err, b_low;
    logic [7:0] exp_echo [5];
    exp_echo = '{8'h65, 8'h63, 8'h68, 8'h6F, 8'h3E};

    reset_n = 1'b0;
    start   = 1'b0;
    load_echo();
    repeat (3) @(negedge clk);
    check("rst_tx",      32'(tx),      32'd1);
    check("rst_busy",    32'(busy),    32'd0);
    check("rst_done",    32'(done),    32'd0);
    check("rst_rom_ce",  32'(rom_ce),  32'd0);
    check("rst_rom_ad",  32'(rom_ad),  32'd0);
    check("rst_rom_oce", 32'(rom_oce), 32'd1);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Prompt "echo>": five frames, then the terminator fetch.
    b_frames = frame_q.size(); b_done = done_cnt; b_busy = busy_cnt;
    b_ce = rom_ce_cnt; b_err = frame_err;
    pulse_start(s);
    wait_done(b_done, 400, "echo_done_seen");
    repeat (10) @(negedge clk);
    check("echo_frames", 32'(frame_q.size() - b_frames), 32'd5);
    if (frame_q.size() - b_frames == 5) begin
      check("echo_first_wire_bits", 32'(frame_q[b_frames]), 32'h2CA);
      for (int i = 0; i < 5; i++)
        check($sformatf("echo_byte%0d", i), 32'(frame_q[b_frames + i][8:1]), 32'(exp_echo[i]));
      for (int i = 0; i < 4; i++)
        check($sformatf("echo_high_gap%0d", i),
              32'(start_q[b_frames + i + 1] - start_q[b_frames + i] - 36), 32'd6);
      check("echo_first_start_lat", 32'(start_q[b_frames] - s), 32'd3);
    end
    check("echo_frame_err", 32'(frame_err - b_err),  32'd0);
    check("echo_done_cnt",  32'(done_cnt - b_done),  32'd1);
    check("echo_done_cyc",  32'(done_cyc - s),       32'd213);
    check("echo_busy_len",  32'(busy_cnt - b_busy),  32'd212);
    check("echo_rom_ce",    32'(rom_ce_cnt - b_ce),  32'd6);

    // Empty prompt: terminator at address 0.
    load_fill(8'h00);
    b_frames = frame_q.size(); b_done = done_cnt; b_busy = busy_cnt;
    b_ce = rom_ce_cnt; b_low = tx_low_cnt;
    pulse_start(s);
    wait_done(b_done, 20, "empty_done_seen");
    repeat (5) @(negedge clk);
    check("empty_done_cyc", 32'(done_cyc - s),             32'd3);
    check("empty_tx_low",   32'(tx_low_cnt - b_low),       32'd0);
    check("empty_frames",   32'(frame_q.size() - b_frames), 32'd0);
    check("empty_busy_len", 32'(busy_cnt - b_busy),        32'd2);
    check("empty_rom_ce",   32'(rom_ce_cnt - b_ce),        32'd1);
    check("empty_done_cnt", 32'(done_cnt - b_done),        32'd1);

    // Full ROM of 55: sixteen frames, addresses 0..15, no wrap.
    load_fill(8'h55);
    b_frames = frame_q.size(); b_done = done_cnt; b_busy = busy_cnt;
    b_ce = rom_ce_cnt; b_ad = ad_q.size(); b_err = frame_err;
    pulse_start(s);
    wait_done(b_done, 1000, "full_done_seen");
    repeat (10) @(negedge clk);
    check("full_frames",   32'(frame_q.size() - b_frames), 32'd16);
    check("full_rom_ce",   32'(rom_ce_cnt - b_ce),         32'd16);
    if (frame_q.size() - b_frames == 16)
      for (int i = 0; i < 16; i++)
        check($sformatf("full_byte%0d", i), 32'(frame_q[b_frames + i][8:1]), 32'hAA);
    if (ad_q.size() - b_ad == 16)
      for (int i = 0; i < 16; i++)
        check($sformatf("full_rom_ad%0d", i), 32'(ad_q[b_ad + i]), 32'(i));
    check("full_frame_err", 32'(frame_err - b_err), 32'd0);
    check("full_done_cyc",  32'(done_cyc - s),      32'd673);
    check("full_busy_len",  32'(busy_cnt - b_busy), 32'd672);
    check("full_done_cnt",  32'(done_cnt - b_done), 32'd1);

    // Start re-pulsed mid-run and in the FIN cycle: both ignored.
    load_echo();
    b_frames = frame_q.size(); b_done = done_cnt; b_busy = busy_cnt; b_ce = rom_ce_cnt;
    pulse_start(s);
    while (cyc < s + 60) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < s + 213) @(negedge clk);
    check("fin_cycle_done", 32'(done), 32'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    check("ign_rom_ce",    32'(rom_ce_cnt - b_ce),         32'd6);
    check("ign_done_cnt",  32'(done_cnt - b_done),         32'd1);
    check("ign_frames",    32'(frame_q.size() - b_frames), 32'd5);
    check("ign_busy_len",  32'(busy_cnt - b_busy),         32'd212);
    check("ign_busy_idle", 32'(busy),                      32'd0);

    // Reset during DATA of the third frame, then a clean replay.
    b_done = done_cnt;
    pulse_start(s);
    while (cyc < s + 95) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("abort_tx",     32'(tx),     32'd1);
    check("abort_busy",   32'(busy),   32'd0);
    check("abort_rom_ce", 32'(rom_ce), 32'd0);
    reset_n = 1'b1;
    repeat (60) @(negedge clk);
    check("abort_no_done", 32'(done_cnt - b_done), 32'd0);
    b_frames = frame_q.size(); b_done = done_cnt; b_ce = rom_ce_cnt;
    b_ad = ad_q.size(); b_err = frame_err;
    pulse_start(s);
    wait_done(b_done, 400, "replay_done_seen");
    repeat (10) @(negedge clk);
    check("replay_rom_ce", 32'(rom_ce_cnt - b_ce), 32'd6);
    if (ad_q.size() > b_ad) check("replay_first_ad", 32'(ad_q[b_ad]), 32'd0);
    check("replay_frames", 32'(frame_q.size() - b_frames), 32'd5);
    if (frame_q.size() - b_frames == 5)
      for (int i = 0; i < 5; i++)
        check($sformatf("replay_byte%0d", i), 32'(frame_q[b_frames + i][8:1]), 32'(exp_echo[i]));
    check("replay_frame_err", 32'(frame_err - b_err), 32'd0);
    check("replay_done_cyc",  32'(done_cyc - s),      32'd213);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
